// File: rtl/gpio_pad_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pad_pkg
//
// Shared definitions for the GPIO pad-ring controller:
//   - word addresses of the LO/HI register pairs on the 5-bit register bus
//   - the reset image of the input-enable vector
//   - lo_hi_mask(): which bits of a HI word map onto real pads
// ---------------------------------------------------------------------------
package gpio_pad_pkg;

    // Every register is a LO/HI pair. LO carries pads 31:0 and HI carries
    // pads NUM_BIDIR-1:32. Bit 0 of the address selects the half.
    localparam logic [4:0] ADDR_OUT_LO   = 5'd0;
    localparam logic [4:0] ADDR_OUT_HI   = 5'd1;
    localparam logic [4:0] ADDR_OE_LO    = 5'd2;
    localparam logic [4:0] ADDR_OE_HI    = 5'd3;
    localparam logic [4:0] ADDR_IE_LO    = 5'd4;
    localparam logic [4:0] ADDR_IE_HI    = 5'd5;
    localparam logic [4:0] ADDR_PU_LO    = 5'd6;
    localparam logic [4:0] ADDR_PU_HI    = 5'd7;
    localparam logic [4:0] ADDR_PD_LO    = 5'd8;
    localparam logic [4:0] ADDR_PD_HI    = 5'd9;
    localparam logic [4:0] ADDR_CS_LO    = 5'd10;
    localparam logic [4:0] ADDR_CS_HI    = 5'd11;
    localparam logic [4:0] ADDR_SL_LO    = 5'd12;
    localparam logic [4:0] ADDR_SL_HI    = 5'd13;
    localparam logic [4:0] ADDR_IN_LO    = 5'd14;
    localparam logic [4:0] ADDR_IN_HI    = 5'd15;
    localparam logic [4:0] ADDR_RISE_LO  = 5'd16;
    localparam logic [4:0] ADDR_RISE_HI  = 5'd17;
    localparam logic [4:0] ADDR_FALL_LO  = 5'd18;
    localparam logic [4:0] ADDR_FALL_HI  = 5'd19;
    localparam logic [4:0] ADDR_IRQEN_LO = 5'd20;
    localparam logic [4:0] ADDR_IRQEN_HI = 5'd21;

    // Input buffers come out of reset enabled on every pad; the top level
    // takes the low NUM_BIDIR bits of this image.
    localparam logic [63:0] IE_RST_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    // Mask of the HI-word bits that correspond to existing pads
    // (bit k of the HI word is pad 32+k).
    function automatic logic [31:0] lo_hi_mask(input int num_bidir);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < num_bidir - 32) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// ---------------------------------------------------------------------------
// gpio_edge_detect
//
// Brings an asynchronous input vector into the clk_i domain with a two-flop
// synchronizer, keeps one more flop of history ("prev") and produces
// single-cycle rise/fall pulses per bit.
//
// Ports:
//   clk_i    core clock
//   rst_i    synchronous active-high reset, clears all flops to 0
//   async_i  raw pad-to-core inputs (asynchronous)
//   sync_o   synchronized inputs
//   rise_o   sync & ~prev
//   fall_o   ~sync & prev
// ---------------------------------------------------------------------------
module gpio_edge_detect #(
    parameter int WIDTH = 54
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_q;
        logic sync_q;
        logic prev_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                meta_q <= async_i[gi];
                sync_q <= meta_q;
                prev_q <= sync_q;
            end
        end

        assign sync_o[gi] = sync_q;
        assign rise_o[gi] = sync_q & ~prev_q;
        assign fall_o[gi] = ~sync_q & prev_q;
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_pad_ctrl
//
// Core-side controller for the bidirectional pad ring. A single-cycle
// register bus programs the per-pad control vectors (data, OE, IE, CS, SL,
// PU, PD); pad inputs are synchronized, edge-detected into sticky
// write-1-to-clear pending registers and combined with IRQ_EN into a
// registered level interrupt.
//
// Ports:
//   clk_i, rst_i            core clock, synchronous active-high reset
//   bus_addr/wdata/we/re    register bus (single-cycle strobes)
//   bus_rdata, bus_rvalid   read return, one cycle after bus_re; rdata is 0
//                           whenever rvalid is low
//   irq                     registered |(pending & irq_en)
//   io_in                   pad-to-core data (asynchronous)
//   io_out, io_oe, io_ie,
//   io_cs, io_sl, io_pu,
//   io_pd                   registered pad controls
// ---------------------------------------------------------------------------
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int NUM_BIDIR = 54
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           bus_addr,
    input  logic [31:0]          bus_wdata,
    input  logic                 bus_we,
    input  logic                 bus_re,
    output logic [31:0]          bus_rdata,
    output logic                 bus_rvalid,
    output logic                 irq,
    input  logic [NUM_BIDIR-1:0] io_in,
    output logic [NUM_BIDIR-1:0] io_out,
    output logic [NUM_BIDIR-1:0] io_oe,
    output logic [NUM_BIDIR-1:0] io_ie,
    output logic [NUM_BIDIR-1:0] io_cs,
    output logic [NUM_BIDIR-1:0] io_sl,
    output logic [NUM_BIDIR-1:0] io_pu,
    output logic [NUM_BIDIR-1:0] io_pd
);

    localparam int N = NUM_BIDIR;

    // The LO/HI word split only works for 33..64 pads.
    if ((NUM_BIDIR < 33) || (NUM_BIDIR > 64)) begin : g_bad_num_bidir
        $error("gpio_pad_ctrl: NUM_BIDIR must be in 33..64");
    end

    // -----------------------------------------------------------------------
    // Word helpers
    // -----------------------------------------------------------------------
    // Replace the LO or HI half of a pad vector with a bus word. HI bits that
    // land beyond the last pad simply have nowhere to go.
    function automatic logic [N-1:0] wr_merge(input logic [N-1:0] cur,
                                              input logic         hi,
                                              input logic [31:0]  wd);
        logic [N-1:0] res;
        res = cur;
        for (int b = 0; b < N; b++) begin
            if ((b >= 32) == hi) begin
                res[b] = wd[b % 32];
            end
        end
        return res;
    endfunction

    // Extract the LO or HI half of a pad vector as a bus word.
    function automatic logic [31:0] rd_word(input logic [N-1:0] vec,
                                            input logic         hi);
        logic [63:0] ext;
        ext        = '0;
        ext[N-1:0] = vec;
        return hi ? (ext[63:32] & lo_hi_mask(N)) : ext[31:0];
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [N-1:0] out_q,       out_d;
    logic [N-1:0] oe_q,        oe_d;
    logic [N-1:0] ie_q,        ie_d;
    logic [N-1:0] pu_q,        pu_d;
    logic [N-1:0] pd_q,        pd_d;
    logic [N-1:0] cs_q,        cs_d;
    logic [N-1:0] sl_q,        sl_d;
    logic [N-1:0] rise_pend_q, rise_pend_d;
    logic [N-1:0] fall_pend_q, fall_pend_d;
    logic [N-1:0] irq_en_q,    irq_en_d;
    logic [N-1:0] pd_pad_q,    pd_pad_d;
    logic [31:0]  rdata_q,     rdata_d;
    logic         rvalid_q,    rvalid_d;
    logic         irq_q,       irq_d;

    logic [N-1:0] sync_vec;
    logic [N-1:0] edge_rise;
    logic [N-1:0] edge_fall;
    logic [N-1:0] in_vis;
    logic [N-1:0] rise_clr;
    logic [N-1:0] fall_clr;
    logic [31:0]  rd_word_sel;
    logic         hi_sel;

    assign hi_sel = bus_addr[0];

    // -----------------------------------------------------------------------
    // Input path
    // -----------------------------------------------------------------------
    gpio_edge_detect #(
        .WIDTH (N)
    ) u_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (io_in),
        .sync_o  (sync_vec),
        .rise_o  (edge_rise),
        .fall_o  (edge_fall)
    );

    // Pads with their input buffer disabled read as 0 and never flag edges.
    assign in_vis = sync_vec & ie_q;

    // -----------------------------------------------------------------------
    // Register-file next state
    // -----------------------------------------------------------------------
    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        ie_d     = ie_q;
        pu_d     = pu_q;
        pd_d     = pd_q;
        cs_d     = cs_q;
        sl_d     = sl_q;
        irq_en_d = irq_en_q;
        rise_clr = '0;
        fall_clr = '0;

        if (bus_we) begin
            case (bus_addr)
                ADDR_OUT_LO,   ADDR_OUT_HI:   out_d    = wr_merge(out_q,    hi_sel, bus_wdata);
                ADDR_OE_LO,    ADDR_OE_HI:    oe_d     = wr_merge(oe_q,     hi_sel, bus_wdata);
                ADDR_IE_LO,    ADDR_IE_HI:    ie_d     = wr_merge(ie_q,     hi_sel, bus_wdata);
                ADDR_PU_LO,    ADDR_PU_HI:    pu_d     = wr_merge(pu_q,     hi_sel, bus_wdata);
                ADDR_PD_LO,    ADDR_PD_HI:    pd_d     = wr_merge(pd_q,     hi_sel, bus_wdata);
                ADDR_CS_LO,    ADDR_CS_HI:    cs_d     = wr_merge(cs_q,     hi_sel, bus_wdata);
                ADDR_SL_LO,    ADDR_SL_HI:    sl_d     = wr_merge(sl_q,     hi_sel, bus_wdata);
                ADDR_RISE_LO,  ADDR_RISE_HI:  rise_clr = wr_merge({N{1'b0}}, hi_sel, bus_wdata);
                ADDR_FALL_LO,  ADDR_FALL_HI:  fall_clr = wr_merge({N{1'b0}}, hi_sel, bus_wdata);
                ADDR_IRQEN_LO, ADDR_IRQEN_HI: irq_en_d = wr_merge(irq_en_q, hi_sel, bus_wdata);
                default: ; // IN is read-only; 22..31 are unmapped
            endcase
        end

        // Clear first, then OR in new edges: a fresh edge beats a
        // simultaneous write-1-to-clear on the same bit.
        rise_pend_d = (rise_pend_q & ~rise_clr) | (edge_rise & ie_q);
        fall_pend_d = (fall_pend_q & ~fall_clr) | (edge_fall & ie_q);

        // Pull-up wins a PU/PD conflict at the pad; the PD register itself
        // keeps what software wrote.
        pd_pad_d = pd_d & ~pu_d;
    end

    // -----------------------------------------------------------------------
    // Read mux (uses current register values, so a same-cycle write is not
    // visible to the read)
    // -----------------------------------------------------------------------
    always_comb begin
        rd_word_sel = '0;
        case (bus_addr)
            ADDR_OUT_LO,   ADDR_OUT_HI:   rd_word_sel = rd_word(out_q,       hi_sel);
            ADDR_OE_LO,    ADDR_OE_HI:    rd_word_sel = rd_word(oe_q,        hi_sel);
            ADDR_IE_LO,    ADDR_IE_HI:    rd_word_sel = rd_word(ie_q,        hi_sel);
            ADDR_PU_LO,    ADDR_PU_HI:    rd_word_sel = rd_word(pu_q,        hi_sel);
            ADDR_PD_LO,    ADDR_PD_HI:    rd_word_sel = rd_word(pd_q,        hi_sel);
            ADDR_CS_LO,    ADDR_CS_HI:    rd_word_sel = rd_word(cs_q,        hi_sel);
            ADDR_SL_LO,    ADDR_SL_HI:    rd_word_sel = rd_word(sl_q,        hi_sel);
            ADDR_IN_LO,    ADDR_IN_HI:    rd_word_sel = rd_word(in_vis,      hi_sel);
            ADDR_RISE_LO,  ADDR_RISE_HI:  rd_word_sel = rd_word(rise_pend_q, hi_sel);
            ADDR_FALL_LO,  ADDR_FALL_HI:  rd_word_sel = rd_word(fall_pend_q, hi_sel);
            ADDR_IRQEN_LO, ADDR_IRQEN_HI: rd_word_sel = rd_word(irq_en_q,    hi_sel);
            default:                      rd_word_sel = '0;
        endcase

        rvalid_d = bus_re;
        rdata_d  = bus_re ? rd_word_sel : 32'h0;
        irq_d    = |((rise_pend_q | fall_pend_q) & irq_en_q);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q       <= '0;
            oe_q        <= '0;
            ie_q        <= IE_RST_ALL[N-1:0];
            pu_q        <= '0;
            pd_q        <= '0;
            cs_q        <= '0;
            sl_q        <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            irq_en_q    <= '0;
            pd_pad_q    <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            ie_q        <= ie_d;
            pu_q        <= pu_d;
            pd_q        <= pd_d;
            cs_q        <= cs_d;
            sl_q        <= sl_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            irq_en_q    <= irq_en_d;
            pd_pad_q    <= pd_pad_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            irq_q       <= irq_d;
        end
    end

    assign io_out     = out_q;
    assign io_oe      = oe_q;
    assign io_ie      = ie_q;
    assign io_cs      = cs_q;
    assign io_sl      = sl_q;
    assign io_pu      = pu_q;
    assign io_pd      = pd_pad_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign irq        = irq_q;

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Core-side controller for the bidirectional pad ring. Converts a simple single-cycle register bus into the per-pad control vectors the `gf180mcu` bidir pads consume: output data, OE, IE, CS, SL, PU and PD. It also samples the pad-to-core inputs through a synchronizer, detects edges and raises a level interrupt. It sits inside the user project, directly behind the `io_*` ports that connect to the 54 bidir pads.

## Interface
- `NUM_BIDIR`, default 54: number of pads. Legal range is 33..64; the range is checked at elaboration.
- `clk_i` input 1: core clock, taken from the Schmitt-trigger clock pad.
- `rst_i` input 1: synchronous, active-high reset.
- `bus_addr` input 5: word address.
- `bus_wdata` input 32: write data.
- `bus_we` input 1: write strobe, single cycle.
- `bus_re` input 1: read strobe, single cycle.
- `bus_rdata` output 32: read data.
- `bus_rvalid` output 1: read data valid, one cycle after `bus_re`.
- `irq` output 1: level interrupt, equal to `|(pend & irq_en)`.
- `io_in` input NUM_BIDIR: pad-to-core data. Asynchronous.
- `io_out` output NUM_BIDIR: core-to-pad data.
- `io_oe`, `io_ie`, `io_cs`, `io_sl`, `io_pu`, `io_pd` output NUM_BIDIR each: pad controls.

## Operation
- **Register map.** Each register is a pair of words: LO holds bits 31:0 and HI holds bits NUM_BIDIR-1:32. HI bits above NUM_BIDIR-33 read 0 and ignore writes.
  - 0/1 OUT
  - 2/3 OE
  - 4/5 IE
  - 6/7 PU
  - 8/9 PD
  - 10/11 CS
  - 12/13 SL
  - 14/15 IN (read-only)
  - 16/17 RISE_PEND (write-1-to-clear)
  - 18/19 FALL_PEND (write-1-to-clear)
  - 20/21 IRQ_EN
- **Unmapped addresses.** Addresses 22..31 read 0 and ignore writes.
- **Writes.** A write to IN is ignored.
- **Input path.**
  - Two-flop synchronizer on `io_in`, giving `sync`.
  - Third flop holds `prev`.
  - Rise is detected when `sync & ~prev`; fall when `~sync & prev`.
  - Detection is gated by `io_ie`: a pad with IE=0 never sets a pending bit, and its IN reads 0.
- **Pending bits.** Pending bits are sticky.
  - A write-1-to-clear and a new edge on the same bit in the same cycle: the set wins and the bit stays 1.
  - Writing 0 has no effect.
- **Pull conflict.** When PU=1 and PD=1 for the same pad, `io_pd` is forced to 0 (pull-up wins). The PD register still reads back the value that was written.
- **Bus collision.** `bus_we` and `bus_re` asserted in the same cycle: the write is performed and the read returns the pre-write value.
- **Reset values.**
  - OUT, OE, PU, PD, CS, SL, pending bits and IRQ_EN are all 0.
  - IE is all-1.
  - The synchronizer flops and `prev` are 0.
  - `bus_rdata` = 0, `bus_rvalid` = 0, `irq` = 0.
- **Reset mid-operation.** Reset aborts any outstanding read (`rvalid` = 0 in the next cycle) and clears all pending bits.

## Timing
- **Pad controls.** `io_*` outputs are registered and change the cycle after the write.
- **Read latency.** `bus_rvalid` and `bus_rdata` are valid exactly one cycle after `bus_re`. `bus_rdata` returns to 0 when `bus_rvalid` is low.
- **Input to IN.** A change on `io_in` is visible in IN 2 cycles later, counting from the first rising edge at which it meets setup.
- **Edge to pending.** The pending bit sets 3 cycles after the edge.
- **Pending to irq.** `irq` is registered and follows the pending bit by one further cycle.
- **Clear to irq.** After a write-1-to-clear, `irq` deasserts the cycle after the pending bit clears, provided no other enabled pending bit remains.
- **Minimum pulse.** Input pulses shorter than one clock period may be missed. This is accepted.

## Structure
- **Package `gpio_pad_pkg`:**
  - Register address constants (`ADDR_OUT_LO` .. `ADDR_IRQEN_HI`).
  - Reset constant for IE.
  - Function `lo_hi_mask(NUM_BIDIR)` for HI-word width masking.
- **Sub-module `gpio_edge_detect`:** per-vector synchronizer, `prev` flop and rise/fall pulse generation, parameterized by width. The top level instantiates it once for the full vector.
- **Top-level contents:** the register file, read mux, pull-conflict logic and irq.

## Test plan
- **Reset values.** Assert reset mid-read, then read every address. Expected: all zero except IE_LO = 0xFFFFFFFF and IE_HI = 0x003FFFFF; `rvalid` low in the cycle after reset.
- **Output drive.** Write OUT_HI = 0x3FFFFF and OE_HI = 0x1. Expected: `io_oe[32]` = 1 and `io_out[53:32]` all 1 on the next cycle. A write of 0xFFFFFFFF to OE_HI reads back 0x003FFFFF.
- **Edge detect and irq.** Set IRQ_EN_LO = 0x1, then drive `io_in[0]` 0→1. Expected: IN_LO bit0 after 2 cycles, RISE_LO = 0x1 after 3, `irq` high after 4. Write RISE_LO = 0x1; `irq` falls 2 cycles later.
- **Clear/set collision.** Make a new rising edge on bit 5 land in the same cycle as a write-1-to-clear of RISE_LO bit5. Expected: the bit remains 1.
- **IE gating.** Write IE_LO = 0, then toggle `io_in[3]`. Expected: IN_LO = 0, no pending bits set, `irq` stays 0.
- **Pull conflict and bus collision.** Write PU_LO = PD_LO = 0x10. Expected: `io_pu[4]` = 1, `io_pd[4]` = 0, PD_LO reads 0x10. Then issue a simultaneous write and read to address 0. Expected: the read returns the old OUT_LO value.
